rom_loader: RTL and testbench

Bridges the byte-wide ROM download stream from `data_io` into the two SDRAM write ports (port1: CPU/sound/sprite ROMs, port2: background tile ROM). It buffers download bytes in a small FIFO, routes each byte by address, drives the toggle req/ack handshake, and raises `rom_loaded` once the download has ended and every byte has been written. `rom_loaded` is what releases the game core from reset.

---
 rtl/rom_loader.sv | 174 +++++++++++++++++
 tb/tb_rom_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// ROM download bridge: buffers data_io bytes in a small FIFO and writes each one
// to SDRAM port1 or port2 (tile ROM) over a toggle req/ack handshake.
module rom_loader #(
  parameter logic [24:0] TILE_BASE   = 25'h40000,
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        rom_loaded,
  output logic        busy,
  output logic        overflow,
  output logic        timeout
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = 8;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  state_t            state, state_d;
  fifo_entry_t       mem [FIFO_DEPTH];
  fifo_entry_t       head_c;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_d_c;
  logic [TMO_W-1:0]  tmo_cnt, tmo_next_c;
  logic [24:0]       off_c;
  logic              wr_last, downl_last, sel, done;
  logic              push_c, push_ok_c, drop_c, pop_c, tmo_hit_c;
  logic              empty_c, full_c, sel_c, ack_match_c;
  logic              downl_rise_c, downl_fall_c;
  logic              unused_off;

  // Capture qualification and FIFO bookkeeping
  assign push_c       = ioctl_wr & ~wr_last & ioctl_downl & (ioctl_index == ROM_INDEX);
  assign empty_c      = (count == '0);
  assign full_c       = (count == CNT_W'(FIFO_DEPTH));
  assign push_ok_c    = push_c & (~full_c | pop_c);
  assign drop_c       = push_c & full_c & ~pop_c;
  assign count_d_c    = count + CNT_W'(push_ok_c) - CNT_W'(pop_c);
  assign head_c       = mem[rd_ptr];
  assign sel_c        = (head_c.addr >= TILE_BASE);
  assign off_c        = head_c.addr - TILE_BASE;
  assign unused_off   = ^{off_c[24], off_c[0]};
  assign ack_match_c  = sel ? (port2_ack == port2_req) : (port1_ack == port1_req);
  assign tmo_next_c   = tmo_cnt + TMO_W'(1);
  assign downl_rise_c = ioctl_downl & ~downl_last;
  assign downl_fall_c = ~ioctl_downl & downl_last;

  // Dispatcher next-state
  always_comb begin
    state_d   = state;
    pop_c     = 1'b0;
    tmo_hit_c = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_match_c) begin
          state_d = IDLE;
        end else if (tmo_next_c == TMO_W'(ACK_TIMEOUT)) begin
          tmo_hit_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage carries no reset; occupancy is tracked by count
  always_ff @(posedge clk_sys) begin
    if (push_ok_c) mem[wr_ptr] <= '{addr: ioctl_addr, data: ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tmo_cnt    <= '0;
      wr_last    <= 1'b0;
      downl_last <= 1'b0;
      sel        <= 1'b0;
      done       <= 1'b0;
      rom_loaded <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      port1_req  <= 1'b0;
      port1_a    <= '0;
      port1_ds   <= '0;
      port1_d    <= '0;
      port1_we   <= 1'b0;
      port2_req  <= 1'b0;
      port2_a    <= '0;
      port2_ds   <= '0;
      port2_d    <= '0;
      port2_we   <= 1'b0;
    end else begin
      state      <= state_d;
      wr_last    <= ioctl_wr;
      downl_last <= ioctl_downl;
      count      <= count_d_c;
      busy       <= (count_d_c != '0) || (state_d != IDLE);
      port1_we   <= ioctl_downl;
      port2_we   <= ioctl_downl;
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      // Issue: load only the selected port, the other one holds
      if (pop_c) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        sel     <= sel_c;
        tmo_cnt <= '0;
        if (sel_c) begin
          port2_a   <= off_c[23:1];
          port2_ds  <= {head_c.addr[0], ~head_c.addr[0]};
          port2_d   <= {head_c.data, head_c.data};
          port2_req <= ~port2_req;
        end else begin
          port1_a   <= head_c.addr[23:1];
          port1_ds  <= {head_c.addr[0], ~head_c.addr[0]};
          port1_d   <= {head_c.data, head_c.data};
          port1_req <= ~port1_req;
        end
      end else if (state == WAIT_ACK) begin
        tmo_cnt <= tmo_next_c;
      end
      // Completion tracking; a new download restarts the status flags
      if (downl_rise_c) begin
        rom_loaded <= 1'b0;
        done       <= 1'b0;
        overflow   <= 1'b0;
        timeout    <= 1'b0;
      end else begin
        if (downl_fall_c) done <= 1'b1;
        if (done && empty_c && (state == IDLE)) begin
          rom_loaded <= 1'b1;
          done       <= 1'b0;
        end
      end
      if (drop_c)    overflow <= 1'b1;
      if (tmo_hit_c) timeout  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader; a second instance on index 1 with a short ack timeout.
module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_downl = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;

  logic        port1_req, port2_req, port1_we, port2_we;
  logic        port1_ack, port2_ack;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic        rom_loaded, busy, overflow, timeout;

  logic        t_p1_req, t_p2_req, t_p1_we, t_p2_we;
  logic        t_p1_ack = 1'b0, t_p2_ack = 1'b0;
  logic [22:0] t_p1_a, t_p2_a;
  logic [1:0]  t_p1_ds, t_p2_ds;
  logic [15:0] t_p1_d, t_p2_d;
  logic        t_loaded, t_busy, t_ovf, t_tmo;

  int errors = 0;
  int checks = 0;

  rom_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds),
    .port1_d(port1_d), .port1_we(port1_we),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds),
    .port2_d(port2_d), .port2_we(port2_we),
    .rom_loaded(rom_loaded), .busy(busy), .overflow(overflow), .timeout(timeout)
  );

  rom_loader #(.ROM_INDEX(8'd1), .ACK_TIMEOUT(8)) dut_t (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(t_p1_req), .port1_ack(t_p1_ack), .port1_a(t_p1_a), .port1_ds(t_p1_ds),
    .port1_d(t_p1_d), .port1_we(t_p1_we),
    .port2_req(t_p2_req), .port2_ack(t_p2_ack), .port2_a(t_p2_a), .port2_ds(t_p2_ds),
    .port2_d(t_p2_d), .port2_we(t_p2_we),
    .rom_loaded(t_loaded), .busy(t_busy), .overflow(t_ovf), .timeout(t_tmo)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM ack responder for the main instance
  logic ack_en = 1'b0;
  int   ack_dly = 0;
  int   w1 = 0, w2 = 0;
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      port1_ack <= 1'b0; port2_ack <= 1'b0; w1 <= 0; w2 <= 0;
    end else if (ack_en) begin
      if (port1_req != port1_ack) begin
        if (w1 >= ack_dly) begin port1_ack <= port1_req; w1 <= 0; end
        else w1 <= w1 + 1;
      end
      if (port2_req != port2_ack) begin
        if (w2 >= ack_dly) begin port2_ack <= port2_req; w2 <= 0; end
        else w2 <= w2 + 1;
      end
    end
  end

  // Write monitor: counts req toggles and records what each write carried
  int          p1_cnt = 0, p2_cnt = 0;
  logic        p1_q = 1'b0, p2_q = 1'b0;
  logic [22:0] p1_la, p2_la;
  logic [1:0]  p1_lds, p2_lds;
  logic [15:0] p1_ld, p2_ld;
  always @(negedge clk_sys) begin
    if (port1_req !== p1_q) begin p1_cnt++; p1_la = port1_a; p1_lds = port1_ds; p1_ld = port1_d; end
    if (port2_req !== p2_q) begin p2_cnt++; p2_la = port2_a; p2_lds = port2_ds; p2_ld = port2_d; end
    p1_q = port1_req;
    p2_q = port2_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input int hold);
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    repeat (hold) @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({port1_req, port2_req, port1_we, port2_we} !== 4'b0) begin
      errors++; $display("FAIL reset_req_we: got %b required 0000", {port1_req, port2_req, port1_we, port2_we});
    end
    checks++;
    if ({port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d} !== '0) begin
      errors++; $display("FAIL reset_port_bus: got nonzero port payload");
    end
    checks++;
    if ({rom_loaded, busy, overflow, timeout} !== 4'b0) begin
      errors++; $display("FAIL reset_status: got %b required 0000", {rom_loaded, busy, overflow, timeout});
    end
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_single_byte;
    int b1, b2;
    bit ok;
    ioctl_downl = 1'b1; ack_en = 1'b1; ack_dly = 2;
    repeat (2) @(negedge clk_sys);
    b1 = p1_cnt; b2 = p2_cnt;
    write_byte(25'h08001, 8'hA5, 1);
    checks++;
    if (port1_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_pre_issue: req=%b busy=%b required req=0 busy=1", port1_req, busy);
    end
    @(negedge clk_sys);
    checks++;
    if (port1_req !== 1'b1) begin
      errors++; $display("FAIL single_latency: req=%b required 1", port1_req);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_idle_wait: busy=%b required 0", busy); end
    checks++;
    if (p1_cnt - b1 != 1 || p2_cnt != b2) begin
      errors++; $display("FAIL single_count: p1=%0d p2=%0d required 1 0", p1_cnt - b1, p2_cnt - b2);
    end
    checks++;
    if (p1_la !== 23'h4000 || p1_lds !== 2'b10 || p1_ld !== 16'hA5A5 || port1_we !== 1'b1) begin
      errors++; $display("FAIL single_payload: a=%h ds=%b d=%h we=%b required 4000 10 a5a5 1", p1_la, p1_lds, p1_ld, port1_we);
    end
    ioctl_downl = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (rom_loaded !== 1'b0) begin errors++; $display("FAIL single_loaded_early: got %b required 0", rom_loaded); end
    @(negedge clk_sys);
    checks++;
    if (rom_loaded !== 1'b1) begin errors++; $display("FAIL single_loaded: got %b required 1", rom_loaded); end
  endtask

  task automatic test_routing;
    int b1, b2;
    bit ok;
    ioctl_downl = 1'b1; ack_dly = 0;
    repeat (2) @(negedge clk_sys);
    b1 = p1_cnt; b2 = p2_cnt;
    write_byte(25'h3FFFF, 8'h12, 1);
    write_byte(25'h40000, 8'h34, 1);
    wait_idle(50, ok);
    checks++;
    if (!ok || p1_cnt - b1 != 1 || p2_cnt - b2 != 1) begin
      errors++; $display("FAIL route_count: p1=%0d p2=%0d idle=%0d required 1 1 1", p1_cnt - b1, p2_cnt - b2, ok);
    end
    checks++;
    if (port1_a !== 23'h1FFFF || port1_ds !== 2'b10 || port1_d !== 16'h1212) begin
      errors++; $display("FAIL route_port1: a=%h ds=%b d=%h required 1ffff 10 1212", port1_a, port1_ds, port1_d);
    end
    checks++;
    if (port2_a !== 23'h0 || port2_ds !== 2'b01 || port2_d !== 16'h3434) begin
      errors++; $display("FAIL route_port2: a=%h ds=%b d=%h required 0 01 3434", port2_a, port2_ds, port2_d);
    end
  endtask

  task automatic test_overflow;
    int b1;
    bit ok;
    ack_en = 1'b0;
    b1 = p1_cnt;
    for (int i = 0; i < 6; i++) begin
      write_byte(25'h100 + 25'(2 * i), 8'h10 + 8'(i), 1);
      repeat (2) @(negedge clk_sys);
    end
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b1 || p1_cnt - b1 != 1) begin
      errors++; $display("FAIL ovf_flag: ovf=%b busy=%b issued=%0d required 1 1 1", overflow, busy, p1_cnt - b1);
    end
    ack_en = 1'b1;
    wait_idle(100, ok);
    checks++;
    if (!ok || p1_cnt - b1 != 5) begin
      errors++; $display("FAIL ovf_writes: writes=%0d idle=%0d required 5 1", p1_cnt - b1, ok);
    end
    checks++;
    if (p1_la !== 23'h84 || p1_ld !== 16'h1414 || timeout !== 1'b0) begin
      errors++; $display("FAIL ovf_last: a=%h d=%h tmo=%b required 84 1414 0", p1_la, p1_ld, timeout);
    end
  endtask

  task automatic test_long_strobe;
    int b1;
    bit ok;
    b1 = p1_cnt;
    write_byte(25'h200, 8'h77, 5);
    wait_idle(50, ok);
    checks++;
    if (!ok || p1_cnt - b1 != 1) begin
      errors++; $display("FAIL long_strobe_count: writes=%0d required 1", p1_cnt - b1);
    end
    checks++;
    if (p1_la !== 23'h100 || p1_lds !== 2'b01 || p1_ld !== 16'h7777) begin
      errors++; $display("FAIL long_strobe_payload: a=%h ds=%b d=%h required 100 01 7777", p1_la, p1_lds, p1_ld);
    end
  endtask

  task automatic test_timeout;
    ioctl_index = 8'd1;
    write_byte(25'h300, 8'h55, 1);
    @(negedge clk_sys);
    checks++;
    if (t_p1_req !== 1'b1) begin errors++; $display("FAIL tmo_issue: req=%b required 1", t_p1_req); end
    ioctl_addr = 25'h40002; ioctl_dout = 8'h66; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (6) @(negedge clk_sys);
    checks++;
    if (t_tmo !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b required 0", t_tmo); end
    @(negedge clk_sys);
    checks++;
    if (t_tmo !== 1'b1 || t_p2_req !== 1'b0) begin
      errors++; $display("FAIL tmo_flag: tmo=%b p2req=%b required 1 0", t_tmo, t_p2_req);
    end
    @(negedge clk_sys);
    checks++;
    if (t_p2_req !== 1'b1 || t_p2_a !== 23'h1 || t_p1_req !== 1'b1) begin
      errors++; $display("FAIL tmo_next: p2req=%b p2a=%h p1req=%b required 1 1 1", t_p2_req, t_p2_a, t_p1_req);
    end
    ioctl_index = 8'd0;
  endtask

  task automatic test_restart;
    bit ok;
    ioctl_downl = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (rom_loaded === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || overflow !== 1'b1) begin
      errors++; $display("FAIL restart_loaded: loaded=%0d ovf=%b required 1 1", ok, overflow);
    end
    ioctl_downl = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (rom_loaded !== 1'b0 || overflow !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL restart_clear: loaded=%b ovf=%b tmo=%b required 000", rom_loaded, overflow, timeout);
    end
  endtask

  task automatic test_reset_mid;
    ack_en = 1'b0;
    write_byte(25'h500, 8'h99, 1);
    @(negedge clk_sys);
    checks++;
    if (busy !== 1'b1 || port1_req !== 1'b1 || port2_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: busy=%b p1req=%b p2req=%b required 1 1 1", busy, port1_req, port2_req);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({port1_req, port2_req, busy, port1_we, rom_loaded} !== 5'b0 || port1_a !== 23'h0 || port1_d !== 16'h0) begin
      errors++; $display("FAIL rstmid_async: req=%b%b busy=%b we=%b a=%h required all 0", port1_req, port2_req, busy, port1_we, port1_a);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b0 || port1_req !== 1'b0 || port1_we !== 1'b1) begin
      errors++; $display("FAIL rstmid_after: busy=%b req=%b we=%b required 0 0 1", busy, port1_req, port1_we);
    end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_routing;
    test_overflow;
    test_long_strobe;
    test_timeout;
    test_restart;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
